// File: rtl/addsub_pkg.sv
// Shared constants, flag bundle and saturation-limit helpers for the
// pipelined adder-subtractor.
package addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Widest operand the saturation helpers can describe.
    localparam int unsigned SAT_FN_W = 64;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } addsub_flags_t;

    // Largest positive two's-complement value of the given width (0111..1).
    function automatic logic [SAT_FN_W-1:0] sat_max_f(input int unsigned width);
        logic [SAT_FN_W-1:0] m;
        m = {SAT_FN_W{1'b0}};
        for (int unsigned i = 0; i + 1 < width; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    // Most negative two's-complement value of the given width (1000..0).
    function automatic logic [SAT_FN_W-1:0] sat_min_f(input int unsigned width);
        logic [SAT_FN_W-1:0] m;
        m = {SAT_FN_W{1'b0}};
        if (width > 0 && width <= SAT_FN_W) begin
            m[width-1] = 1'b1;
        end else begin
            m = {SAT_FN_W{1'b0}};
        end
        return m;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain chunk: adds a chunk of A, effective B and a carry-in,
// exposing the chunk carry-out and the carry into the chunk MSB.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] be,
    input  logic          carry_in,
    output logic [CW-1:0] sum,
    output logic          carry_out,
    output logic          carry_msb
);

    logic [CW:0] full_s;

    assign full_s    = {1'b0, a} + {1'b0, be} + {{CW{1'b0}}, carry_in};
    assign sum       = full_s[CW-1:0];
    assign carry_out = full_s[CW];
    // The MSB sum bit is a^be^carry_into_msb, so the incoming carry falls out by XOR.
    assign carry_msb = full_s[CW-1] ^ a[CW-1] ^ be[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: the carry chain is split into STAGES chunks with a
// registered carry between them; flags and saturation sit in the last stage.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             add_sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STG_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int CW       = WIDTH / STG_SAFE;
    localparam int LAST     = STG_SAFE - 1;

    localparam logic [SAT_FN_W-1:0] SAT_MAX_W = sat_max_f(WIDTH);
    localparam logic [SAT_FN_W-1:0] SAT_MIN_W = sat_min_f(WIDTH);
    localparam logic [WIDTH-1:0]    SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SAT_MIN   = SAT_MIN_W[WIDTH-1:0];

    if (STAGES < 1 || (WIDTH % STG_SAFE) != 0 || WIDTH > SAT_FN_W) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a multiple of STAGES, STAGES >= 1");
    end

    // Replace one CW-bit chunk of a word with a freshly computed chunk.
    function automatic logic [WIDTH-1:0] insert_chunk(input logic [WIDTH-1:0] v,
                                                      input logic [CW-1:0]    c,
                                                      input int unsigned      idx);
        logic [WIDTH-1:0] t;
        t = v;
        t[idx*CW +: CW] = c;
        return t;
    endfunction

    logic             adv_s;
    logic [WIDTH-1:0] a_s     [STG_SAFE];
    logic [WIDTH-1:0] b_s     [STG_SAFE];
    logic [WIDTH-1:0] r_s     [STG_SAFE];
    logic [WIDTH-1:0] r_nxt_s [STG_SAFE];
    logic [CW-1:0]    chunk_s [STG_SAFE];
    logic             as_s    [STG_SAFE];
    logic             sat_s   [STG_SAFE];
    logic             cin_s   [STG_SAFE];
    logic             vld_s   [STG_SAFE];
    logic             co_s    [STG_SAFE];
    logic             cm_s    [STG_SAFE];

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    addsub_flags_t    flags_r;
    logic [WIDTH-1:0] sum_nxt_s;
    addsub_flags_t    flags_nxt_s;

    // The whole pipe moves together; a held output freezes every stage.
    assign adv_s    = !out_valid_r || out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < STG_SAFE; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign a_s[0]   = a;
            assign b_s[0]   = b;
            assign r_s[0]   = {WIDTH{1'b0}};
            assign as_s[0]  = add_sub;
            assign sat_s[0] = sat & SAT_EN;
            assign cin_s[0] = cin;
            assign vld_s[0] = in_valid;
        end else begin : g_src
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] r_r;
            logic             as_r;
            logic             sat_r;
            logic             c_r;
            logic             vld_r;

            // Skew register: carry, finished low chunks and pending high operands.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r   <= {WIDTH{1'b0}};
                    b_r   <= {WIDTH{1'b0}};
                    r_r   <= {WIDTH{1'b0}};
                    as_r  <= 1'b0;
                    sat_r <= 1'b0;
                    c_r   <= 1'b0;
                    vld_r <= 1'b0;
                end else if (adv_s) begin
                    a_r   <= a_s[k-1];
                    b_r   <= b_s[k-1];
                    r_r   <= r_nxt_s[k-1];
                    as_r  <= as_s[k-1];
                    sat_r <= sat_s[k-1];
                    c_r   <= co_s[k-1];
                    vld_r <= vld_s[k-1];
                end
            end

            assign a_s[k]   = a_r;
            assign b_s[k]   = b_r;
            assign r_s[k]   = r_r;
            assign as_s[k]  = as_r;
            assign sat_s[k] = sat_r;
            assign cin_s[k] = c_r;
            assign vld_s[k] = vld_r;
        end

        addsub_slice #(.CW(CW)) u_slice (
            .a         (a_s[k][k*CW +: CW]),
            .be        (b_s[k][k*CW +: CW] ^ {CW{as_s[k] == SUB}}),
            .carry_in  (cin_s[k]),
            .sum       (chunk_s[k]),
            .carry_out (co_s[k]),
            .carry_msb (cm_s[k])
        );

        assign r_nxt_s[k] = insert_chunk(r_s[k], chunk_s[k], k);
    end

    // Final-stage saturation mux and flags; cout/ovf always describe the raw sum.
    always_comb begin
        sum_nxt_s        = r_nxt_s[LAST];
        flags_nxt_s.cout = co_s[LAST];
        flags_nxt_s.ovf  = cm_s[LAST] ^ co_s[LAST];
        if (sat_s[LAST] && flags_nxt_s.ovf) begin
            if (a_s[LAST][WIDTH-1]) begin
                sum_nxt_s = SAT_MIN;
            end else begin
                sum_nxt_s = SAT_MAX;
            end
        end else begin
            sum_nxt_s = r_nxt_s[LAST];
        end
        flags_nxt_s.zero = (sum_nxt_s == {WIDTH{1'b0}});
        flags_nxt_s.neg  = sum_nxt_s[WIDTH-1];
    end

    // Output register: the last pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            flags_r     <= '{cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0};
        end else if (adv_s) begin
            out_valid_r <= vld_s[LAST];
            sum_r       <= sum_nxt_s;
            flags_r     <= flags_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = flags_r.cout;
    assign ovf       = flags_r.ovf;
    assign zero      = flags_r.zero;
    assign neg       = flags_r.neg;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined signed/unsigned adder-subtractor: the next generation of the team's 8-bit combinational add/sub unit. It keeps the same operand semantics (`b` XOR-complemented by `add_sub`, plus user `cin`) but generalises width and splits the carry chain over `STAGES` register stages. It adds valid/ready handshakes with backpressure, status flags and optional signed saturation. It sits between an operand-issue stage and a result writeback/consumer stage.

## Interface
- `WIDTH`, 16: operand/result width; must be divisible by `STAGES`.
- `STAGES`, 2: pipeline stages, in the range 1..WIDTH; each stage resolves a `WIDTH/STAGES`-bit carry chunk.
- `SAT_EN`, 1: 1 builds the saturation logic; 0 ties `sat` off internally.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in; the caller sets it to 1 for a true two's-complement subtract.
- `add_sub`  in  1  0 = add, 1 = subtract (B complemented).
- `sat`  in  1  1 = clamp on signed overflow.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  raw carry out of the MSB.
- `ovf`  out  1  signed overflow of the unsaturated result.
- `zero`  out  1  final `sum` == 0.
- `neg`  out  1  final `sum[WIDTH-1]`.

## Operation
- Effective B: `be = b ^ {WIDTH{add_sub}}`. Raw result: `{cout, r} = a + be + cin`, computed in WIDTH+1 bits, no truncation before the carry.
- `ovf` = carry into MSB XOR carry out of MSB, equivalently `(a[MSB]==be[MSB]) && (r[MSB]!=a[MSB])`.
- Saturation applies only when `sat` is 1, `SAT_EN` is 1 and `ovf` is 1:
  - if `a[MSB]` is 0, `sum` = `0111…1`;
  - otherwise `sum` = `1000…0`.
- Without saturation, `sum = r`. `cout` and `ovf` always report the raw result.
- `zero` and `neg` are derived from the final (post-saturation) `sum`.
- Pipeline organisation:
  - Stage k computes chunk k, LSB chunk first.
  - The carry between chunks is registered.
  - Upper operand chunks, `add_sub`, `sat` and the lower result chunks are skew-registered alongside the carry.
  - The saturation mux and the flags are computed in the final stage.
- Each stage has a valid bit.
- There is a single global advance enable: `adv = !out_valid || out_ready`, and `in_ready = adv`.
- Bubbles are not squeezed; the pipeline stalls as a whole.
- Handshake rules:
  - A beat is accepted on an edge where `in_valid && in_ready`.
  - A beat is consumed on an edge where `out_valid && out_ready`.
  - Both can occur on the same edge when the pipeline is full; this gives throughput of one beat per cycle.
- While `out_valid && !out_ready`, all outputs hold stable and no upstream stage advances.
- Inputs are sampled only on accepting edges. Their values are don't-care otherwise.
- `in_ready` may depend combinationally on `out_ready`. No other combinational input-to-output path exists.

## Timing
- Reset (asynchronous, immediate): all stage valid bits, data registers, `sum`, `cout`, `ovf`, `zero` and `neg` go to 0. `out_valid` goes to 0. `in_ready` reads 1 while `rst` is high.
- Latency: a beat accepted on edge N presents `out_valid`=1 after edge N+STAGES-1 when there is no stall. With STAGES=1, the result is visible in the cycle after acceptance.
- Results emerge in acceptance order. No beat is dropped or duplicated under any `out_ready` pattern.
- Reset mid-operation discards all in-flight beats; none emerges after `rst` deasserts.
- Wrap-around: unsigned overflow wraps with `cout`=1. For example, `FFFF+0001` gives `sum` 0000, `cout` 1, `zero` 1.
- An elaboration error is raised if `WIDTH % STAGES != 0` or `STAGES < 1`.

## Structure
- Package `addsub_pkg` holds:
  - `ADD`=1'b0 and `SUB`=1'b1 opcode constants;
  - a `addsub_flags_t` struct {cout, ovf, zero, neg};
  - the saturation max/min constant functions of WIDTH.
- Sub-module `addsub_slice`: one `WIDTH/STAGES`-bit chunk adder (a, be, carry_in → chunk sum, carry_out, carry into chunk MSB).
  - It is instantiated STAGES times in a generate loop.
  - The top level owns the registers, the skew pipelines, the flags and the handshake.

## Test plan
- WIDTH=16, STAGES=2, add: `a`=00FF, `b`=0001, `cin`=0 → `sum` 0100, `cout` 0, `ovf` 0, `zero` 0, `neg` 0. Confirms the carry crosses the chunk boundary and the latency is 2 edges.
- Subtract: `a`=0005, `b`=0007, `add_sub`=1, `cin`=1 → `sum` FFFE, `cout` 0, `neg` 1. Also `a`=1234, `b`=1234 → `sum` 0000, `cout` 1, `zero` 1.
- Overflow positive: 7FFF + 0001 with `sat`=1 → `sum` 7FFF, `ovf` 1. With `sat`=0 → `sum` 8000, `ovf` 1, `neg` 1.
- Overflow negative: 8000 - 0001 (`cin`=1) with `sat`=1 → `sum` 8000, `ovf` 1.
- Backpressure: 6 back-to-back beats with `out_ready` held low for 3 cycles mid-stream → `in_ready` drops, outputs are stable while stalled, all 6 results arrive in order with none lost.
- Reset with 2 beats in flight → `out_valid` is 0 immediately. After release, no stale result appears, and a new beat returns its correct result after STAGES edges.
